// File: rtl/processador_multicanal.sv
// N-channel four-phase sender: round-robin issue of sequence words to idle channels,
// per-channel REQ/REL handshake, payload holding and a completion popcount counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | channel free; eligible for a grant when en and mask[i] are set
// ST_REQ  | send[i]=1, payload held, waiting for ack[i] high
// ST_REL  | send[i]=0, payload held, waiting for ack[i] low (completion)
module processador_multicanal #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned START_VAL = 0,
  parameter int unsigned STEP      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_CH-1:0]          mask,
  input  logic [N_CH-1:0]          ack,
  output logic [N_CH-1:0]          send,
  output logic [N_CH*DATA_W-1:0]   dado,
  output logic [N_CH-1:0]          busy,
  output logic [CNT_W-1:0]         done_cnt
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t              state_q [N_CH];
  state_t              state_d [N_CH];
  logic [DATA_W-1:0]   seq_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [N_CH-1:0]     elig;
  logic [N_CH-1:0]     grant_vec;
  logic [N_CH-1:0]     complete;
  logic                found;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    scan_idx;
  logic [CNT_W-1:0]    n_done;

  function automatic logic [PTR_W-1:0] add_mod(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = ({{(32-PTR_W){1'b0}}, base} + off) % N_CH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = en && mask[i] && (state_q[i] == ST_IDLE);
    end
  end

  // Scan starts at ptr so the channel after the last grant has priority.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = add_mod(ptr_q, k);
      if (!found && elig[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      grant_vec[i] = found && (grant_idx == PTR_W'(i));
    end
  end

  always_comb begin
    complete = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (grant_vec[i]) state_d[i] = ST_REQ;
        ST_REQ:  if (ack[i])       state_d[i] = ST_REL;
        ST_REL: begin
          if (!ack[i]) begin
            state_d[i]  = ST_IDLE;
            complete[i] = 1'b1;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    n_done = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_done = n_done + CNT_W'(complete[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
      send     <= '0;
      busy     <= '0;
      dado     <= '0;
      seq_q    <= DATA_W'(START_VAL);
      ptr_q    <= '0;
      done_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        send[i]    <= (state_d[i] == ST_REQ);
        busy[i]    <= (state_d[i] != ST_IDLE);
        if (grant_vec[i]) begin
          dado[i*DATA_W +: DATA_W] <= seq_q;
        end
      end
      if (found) begin
        seq_q <= seq_q + DATA_W'(STEP);
        ptr_q <= add_mod(grant_idx, 1);
      end
      done_cnt <= done_cnt + n_done;
    end
  end

endmodule

// File: doc/processador_multicanal.md
# processador_multicanal

Parametrised processor-side sender that drives N independent send/ack channels, each running its own four-phase handshake and carrying its own data word. Data words come from a shared sequence generator and are issued to idle channels by a round-robin arbiter. Successor to the two-channel processor FSM: it adds N channels, per-channel payload holding, enable/mask control and a completion counter. Sits between the processor data source and the downstream receiver FSMs.

## Interface
- N_CH, 4: number of channels (2..16)
- DATA_W, 16: payload width per channel
- CNT_W, 16: width of completion counter
- START_VAL, 0: sequence generator reset value (DATA_W bits)
- STEP, 1: sequence increment per issued word

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  global issue enable
- mask  in  N_CH  per-channel issue enable
- ack  in  N_CH  receiver acknowledge, one bit per channel
- send  out  N_CH  request, one bit per channel (registered)
- dado  out  N_CH*DATA_W  payload; channel i occupies bits [i*DATA_W +: DATA_W] (registered)
- busy  out  N_CH  channel i not in IDLE
- done_cnt  out  CNT_W  total completed handshakes, all channels

## Operation
- One clock and one reset. Reset is synchronous and active-high. All outputs are registered.
- Reset values: send=0, dado=0, busy=0, done_cnt=0. Internally: sequence register seq=START_VAL, round-robin pointer ptr=0, all channel states IDLE.
- Per-channel FSM, 3 states:
  - IDLE: send=0.
  - REQ: send=1, dado slice held. Moves to REL when ack[i]=1 is sampled.
  - REL: send=0, dado slice held. Moves to IDLE when ack[i]=0 is sampled; this move is one completion.
- Issue:
  - Each cycle with en=1, the eligible set is the channels with state IDLE and mask[i]=1.
  - If the set is non-empty, grant exactly one channel g: the first eligible index found scanning ptr, ptr+1, ... mod N_CH.
  - At the edge: dado slice g <= seq; seq <= seq+STEP (mod 2^DATA_W); state g <= REQ; ptr <= (g+1) mod N_CH.
  - If no channel is granted, seq and ptr hold.
- Eligibility uses the registered state. A channel that returns to IDLE at edge t can be granted no earlier than the cycle after edge t.
- ack[i] is ignored in IDLE. ack[i] is ignored while REQ already has ack high, beyond causing the transition.
- done_cnt adds the number of channels that complete at each edge. This is a popcount, 0..N_CH. done_cnt wraps mod 2^CNT_W.
- en=0 or mask[i]=0 only blocks new grants. In-flight handshakes finish normally.
- dado slice for channel i changes only on a grant to i (or on reset). After completion it keeps the last word.
- Reset during any state: all channels return to IDLE and send drops to 0 at that edge. The in-flight word is lost; seq returns to START_VAL.

## Timing
- Grant in cycle t: send[g]=1 and the new dado slice are visible from edge t+1.
- ack[g] sampled high at edge t+k: send[g]=0 from that edge (REQ to REL).
- ack[g] sampled low at edge t+m: busy[g]=0 and done_cnt updated from that edge.
- Minimum cycle per channel is 4 edges: grant, ack high, ack low, re-grant.
- Arbiter throughput: at most one grant per cycle, all channels combined. Completions can coincide on any number of channels.
- Required ack protocol: ack[i] rises only while send[i]=1 and falls only after send[i]=0. The block does not check this. A violation only delays the transitions; it never corrupts other channels.

## Test plan
- Reset check: assert rst for 2 cycles mid-activity -> send=0, dado=0, busy=0, done_cnt=0. The first grant after release carries dado=START_VAL.
- Single channel (N_CH=4, mask=0001, en=1): receiver acks 2 cycles after send. Expect send[0] pulses with dado[15:0]=0, then 1, then 2. done_cnt increments by 1 per completion; send[3:1] stay 0.
- Round-robin fill (mask=1111, ack held 0): channels 0,1,2,3 granted on 4 consecutive cycles with words 0,1,2,3. No further grants while all are in REQ.
- Round-robin fairness: only channels 1 and 3 eligible with ptr=2. The first grant goes to 3, the next to 1.
- Simultaneous completion: channels 0,2,3 drop ack on the same cycle while in REL. done_cnt jumps by 3 in one edge; busy goes to 0010.
- Wrap (DATA_W=4, START_VAL=14, STEP=1, CNT_W=2): issued words are 14, 15, 0, 1. After 5 completions done_cnt=1. en=0 asserted mid-REQ: that handshake completes and no new send is raised.
